// File: rtl/mem_access_unit_if.sv
// Request/response and RAM-side signal bundle for mem_access_unit.
// slave = the unit itself; master = CPU datapath plus RAM (or a bench standing in for both).
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic        ram_enw;
    logic [31:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, ram_address, ram_wdata, ram_enw
    );
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, ram_address, ram_wdata, ram_enw
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end onto a single-port word RAM; sub-word stores use read-modify-write.
// Define MAU_BOUNDS_CHECK_EN to flag accesses beyond DEPTH words as errors instead of wrapping.
module mem_access_unit #(
    parameter int DEPTH = 2048
) (
    input logic             clock,
    input logic             reset,
    mem_access_unit_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [15:0] wdata_q;

    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        req_err = (bus.req_size == 2'd3) ||
                  (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                  (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0);
`ifdef MAU_BOUNDS_CHECK_EN
        if (bus.req_addr[31:2] >= 30'(DEPTH)) req_err = 1'b1;
`endif
    end

`ifndef MAU_BOUNDS_CHECK_EN
    // Without bounds checking the index simply wraps, so the high address bits go nowhere.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:IDX_W+2];
`endif

    always_comb begin
        byte_sel = bus.ram_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = bus.ram_rdata;
        endcase
        merged = bus.ram_rdata;
        if (size_q == 2'd0) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            lane_q          <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            wdata_q         <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_rdata  <= '0;
            bus.resp_err    <= 1'b0;
            bus.ram_address <= '0;
            bus.ram_wdata   <= '0;
            bus.ram_enw     <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    lane_q          <= bus.req_addr[1:0];
                    size_q          <= bus.req_size;
                    uns_q           <= bus.req_unsigned;
                    wdata_q         <= bus.req_wdata[15:0];
                    bus.ram_address <= 32'(bus.req_addr[IDX_W+1:2]);
                    if (req_err) begin
                        bus.resp_rdata <= '0;
                        bus.resp_err   <= 1'b1;
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else if (!bus.req_we) begin
                        state <= LOAD;
                    end else if (bus.req_size == 2'd2) begin
                        bus.ram_wdata <= bus.req_wdata;
                        bus.ram_enw   <= 1'b1;
                        state         <= WRITE;
                    end else begin
                        state <= READ;
                    end
                end
                LOAD: begin
                    bus.resp_rdata <= load_ext;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                READ: begin
                    // Address was loaded at accept, so it is already stable for the enw cycle.
                    bus.ram_wdata <= merged;
                    bus.ram_enw   <= 1'b1;
                    state         <= WRITE;
                end
                WRITE: begin
                    bus.ram_enw    <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: reference memory + per-cycle response/write model.
module tb_mem_access_unit;
    localparam int DEPTH = 2048;
    localparam int IDX_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_unit_if bus();
    mem_access_unit #(.DEPTH(DEPTH)) dut (.clock(clk), .reset(rst), .bus(bus));

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        mem_ready = 1'b0;

    function automatic logic [31:0] init_word(int i);
        if (i == 2) return 32'h80FF7F01;
        return 32'(i) * 32'h9E3779B9;
    endfunction

    assign bus.ram_rdata = mem[bus.ram_address[IDX_W-1:0]];

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
            mem_ready = 1'b1;
        end else if (bus.ram_enw) begin
            mem[bus.ram_address[IDX_W-1:0]] = bus.ram_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour, in plain arithmetic.
    function automatic logic [31:0] m_load(logic [31:0] word, logic [31:0] addr, logic [1:0] size, logic uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (word >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            v = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_merge(logic [31:0] word, logic [31:0] addr, logic [1:0] size, logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        sh   = (size == 2'd0) ? 8 * (addr % 4) : (size == 2'd1) ? 16 * ((addr % 4) / 2) : 0;
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    function automatic logic m_err(logic [31:0] addr, logic [1:0] size);
        logic e;
        e = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
`ifdef MAU_BOUNDS_CHECK_EN
        if (addr / 4 >= DEPTH) e = 1'b1;
`endif
        return e;
    endfunction

    // Expected timeline of the access in flight.
    logic        chk_en = 1'b0;
    logic        e_act = 1'b0;
    int          e_a = 0, e_lat = 0, e_wc = -1;
    logic [31:0] e_rdata = '0, e_widx = '0, e_wword = '0;
    logic        e_err = 1'b0;
    logic        ev, ew;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!(e_act && cyc > e_a && cyc <= e_a + e_lat)));
            ev = e_act && (cyc == e_a + e_lat);
            chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
            if (ev) begin
                chk("resp_rdata", bus.resp_rdata, e_rdata);
                chk("resp_err", 32'(bus.resp_err), 32'(e_err));
            end
            ew = e_act && (cyc == e_wc);
            chk("ram_enw", 32'(bus.ram_enw), 32'(ew));
            if (ew) begin
                chk("ram_address", bus.ram_address, e_widx);
                chk("ram_wdata", bus.ram_wdata, e_wword);
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n;
        int idx;
        logic err;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) chk("ready_timeout", 32'd0, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        idx     = int'((addr / 4) % DEPTH);
        err     = m_err(addr, size);
        e_a     = cyc;
        e_lat   = err ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
        e_err   = err;
        e_rdata = (err || we) ? 32'd0 : m_load(ref_mem[idx], addr, size, uns);
        e_wc    = (!err && we) ? e_a + (size == 2'd2 ? 1 : 2) : -1;
        e_widx  = 32'(idx);
        e_wword = m_merge(ref_mem[idx], addr, size, wd);
        if (!err && we) ref_mem[idx] = e_wword;
        e_act   = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 10);
        if (!bus.resp_valid) chk("resp_timeout", 32'd0, 32'd1);
        chk("latency", 32'(cyc - e_a), 32'(e_lat));
        rd = bus.resp_rdata;
        er = bus.resp_err;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        // Model pins.
        chk("model_b9",   m_load(32'h80FF7F01, 32'h9, 2'd0, 1'b0), 32'h0000007F);
        chk("model_bB_s", m_load(32'h80FF7F01, 32'hB, 2'd0, 1'b0), 32'hFFFFFF80);
        chk("model_hA_s", m_load(32'h80FF7F01, 32'hA, 2'd1, 1'b0), 32'hFFFF80FF);
        chk("model_merge", m_merge(32'h11223344, 32'h13, 2'd0, 32'h000000AB), 32'hAB223344);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_ram_address", bus.ram_address, 32'd0);
        chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
        chk("rst_ram_enw", 32'(bus.ram_enw), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
        chk("wst_mem4", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        chk("wld_data", rd, 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, er);
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, rd, er);
        chk("bst_mem4", mem[4], 32'hAB223344);
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h9999CAFE, rd, er);
        chk("hst_mem4", mem[4], 32'hCAFE3344);

        do_req(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, rd, er); chk("ld_b9_s",  rd, 32'h0000007F);
        do_req(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, rd, er); chk("ld_bB_s",  rd, 32'hFFFFFF80);
        do_req(1'b0, 2'd0, 1'b1, 32'hB, 32'h0, rd, er); chk("ld_bB_u",  rd, 32'h00000080);
        do_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, rd, er); chk("ld_hA_s",  rd, 32'hFFFF80FF);
        do_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, rd, er); chk("ld_hA_u",  rd, 32'h000080FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, rd, er); chk("ld_h8_s",  rd, 32'h00007F01);

        do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, rd, er);
        chk("err_h3", 32'(er), 32'd1); chk("err_h3_rd", rd, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h6, 32'h12345678, rd, er);
        chk("err_w6", 32'(er), 32'd1);
        chk("err_w6_mem1", mem[1], init_word(1));
        do_req(1'b1, 2'd3, 1'b0, 32'h8, 32'h12345678, rd, er);
        chk("err_sz3", 32'(er), 32'd1);
        chk("err_sz3_mem2", mem[2], 32'h80FF7F01);

        // Reset while the byte store sits in READ.
        chk_en = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_addr = 32'h9; bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid_ready_low", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        e_act = 1'b0;
        chk("mid_ready", 32'(bus.req_ready), 32'd1);
        chk("mid_enw", 32'(bus.ram_enw), 32'd0);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_mem2", mem[2], 32'h80FF7F01);

        do_req(1'b1, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0BADF00D, rd, er);
`ifdef MAU_BOUNDS_CHECK_EN
        chk("oob_err", 32'(er), 32'd1);
        chk("oob_mem0", mem[0], init_word(0));
`else
        chk("oob_err", 32'(er), 32'd0);
        chk("oob_mem0", mem[0], 32'h0BADF00D);
`endif
        do_req(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, rd, er); chk("ld_b8_u", rd, 32'h00000001);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
